aurora_bist_prbs_checker: RTL and testbench

Receive-side PRBS15 BIST checker for the Aurora AXIS MAC. It sits on the MAC's PHY-receive word stream and mirrors the MAC's BIST PRBS15 generator. It self-synchronises to the incoming 64-bit PRBS15 stream and reports lock status. While locked, it counts checked words and bit errors for the bist_checker_locked, bist_checker_samps and bist_checker_errors status outputs.

---
 rtl/aurora_bist_prbs_checker.sv | 119 +++++++++++
 tb/tb_aurora_bist_prbs_checker.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_bist_prbs_checker.sv
// PRBS15 receive-side BIST checker for the Aurora AXIS MAC PHY word stream.
// Ports: clk, rst_n (sync, active-low), checker_en, i_tdata[63:0] (bit 63
// earliest), i_tvalid; outputs locked, samps[CNT_W-1:0], errors[CNT_W-1:0].
module aurora_bist_prbs_checker #(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 8,
  parameter int CNT_W        = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             checker_en,
  input  logic [63:0]      i_tdata,
  input  logic             i_tvalid,
  output logic             locked,
  output logic [CNT_W-1:0] samps,
  output logic [CNT_W-1:0] errors
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [3:0] LOCK_C   = 4'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK_C = 8'(UNLOCK_COUNT);

  logic [1:0]     state;
  logic [14:0]    seed;
  logic [3:0]     match_run;
  logic [7:0]     mis_run;
  logic [63:0]    pred;
  logic [63:0]    diff;
  logic [6:0]     pop;
  logic           hit;
  logic [3:0]     match_nxt;
  logic [7:0]     mis_nxt;
  logic [CNT_W:0] err_sum;

  // Seed occupies the 15 bits just before the word; each new bit is
  // b[n-14]^b[n-15], walked from the earliest bit (63) down to 0.
  function automatic logic [63:0] prbs_word(input logic [14:0] s);
    logic [78:0] e;
    e = {s, 64'd0};
    for (int j = 63; j >= 0; j--) begin
      e[j] = e[j+14] ^ e[j+15];
    end
    return e[63:0];
  endfunction

  always_comb begin
    pred      = prbs_word(seed);
    diff      = i_tdata ^ pred;
    pop       = 7'($countones(diff));
    // An all-zero word is the PRBS lockup state, never a valid match.
    hit       = (diff == '0) && (i_tdata != '0);
    match_nxt = hit ? match_run + 4'd1 : 4'd1;
    mis_nxt   = mis_run + 8'd1;
    err_sum   = {1'b0, errors} + (CNT_W+1)'(pop);
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      seed      <= '0;
      match_run <= '0;
      mis_run   <= '0;
      samps     <= '0;
      errors    <= '0;
    end else if (!checker_en) begin
      state     <= IDLE;
      match_run <= '0;
      mis_run   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state     <= SEARCH;
          samps     <= '0;
          errors    <= '0;
          match_run <= '0;
          mis_run   <= '0;
        end
        SEARCH: begin
          if (i_tvalid) begin
            seed <= i_tdata[14:0];
            if (match_nxt == LOCK_C) begin
              state     <= LOCKED;
              match_run <= '0;
              mis_run   <= '0;
            end else begin
              match_run <= match_nxt;
            end
          end
        end
        LOCKED: begin
          if (i_tvalid) begin
            if (samps != '1) samps <= samps + CNT_W'(1);
            errors <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
            // Free-run on the prediction so one bad bit costs one error.
            if (pop == 7'd0) begin
              mis_run <= '0;
              seed    <= pred[14:0];
            end else if (mis_nxt == UNLOCK_C) begin
              state     <= SEARCH;
              mis_run   <= '0;
              match_run <= '0;
              seed      <= i_tdata[14:0];
            end else begin
              mis_run <= mis_nxt;
              seed    <= pred[14:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aurora_bist_prbs_checker.sv
// Randomized bench for aurora_bist_prbs_checker against a bit-queue model.
// A second instance with 10-bit counters exercises saturation.
module tb_aurora_bist_prbs_checker;

  localparam longint SMAX = 1023;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        checker_en;
  logic [63:0] i_tdata;
  logic        i_tvalid;
  logic        locked, locked_s;
  logic [47:0] samps, errors;
  logic [9:0]  samps_s, errors_s;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  aurora_bist_prbs_checker dut (
    .clk(clk), .rst_n(rst_n), .checker_en(checker_en),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid),
    .locked(locked), .samps(samps), .errors(errors)
  );

  aurora_bist_prbs_checker #(.CNT_W(10)) dut_sat (
    .clk(clk), .rst_n(rst_n), .checker_en(checker_en),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid),
    .locked(locked_s), .samps(samps_s), .errors(errors_s)
  );

  // ---- stream generator: serial bit history ----
  bit gq[$];

  function automatic void gen_seed();
    gq.delete();
    repeat (15) gq.push_back(1'b1);
  endfunction

  function automatic logic [63:0] gen_word();
    logic [63:0] w;
    bit nb;
    for (int k = 0; k < 64; k++) begin
      nb = gq[gq.size()-14] ^ gq[gq.size()-15];
      gq.push_back(nb);
      w[63-k] = nb;
    end
    while (gq.size() > 15) void'(gq.pop_front());
    return w;
  endfunction

  // ---- reference model ----
  int       m_st;   // 0 idle, 1 search, 2 locked
  int       m_mrun, m_xrun;
  bit [14:0] m_tail;
  longint   m_samps, m_errors;

  function automatic logic [63:0] predict(input bit [14:0] t);
    bit h[$];
    logic [63:0] w;
    for (int i = 14; i >= 0; i--) h.push_back(t[i]);
    for (int k = 0; k < 64; k++) begin
      h.push_back(h[h.size()-14] ^ h[h.size()-15]);
      w[63-k] = h[h.size()-1];
    end
    return w;
  endfunction

  function automatic int ones(input logic [63:0] x);
    int n = 0;
    for (int i = 0; i < 64; i++) if (x[i]) n++;
    return n;
  endfunction

  function automatic longint sat(input longint v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  function automatic void model_step(input logic r, input logic e,
                                     input logic v, input logic [63:0] d);
    logic [63:0] p;
    int n;
    if (!r) begin
      m_st = 0; m_mrun = 0; m_xrun = 0; m_tail = '0;
      m_samps = 0; m_errors = 0;
    end else if (!e) begin
      m_st = 0; m_mrun = 0; m_xrun = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_mrun = 0; m_xrun = 0; m_samps = 0; m_errors = 0;
    end else if (v) begin
      p = predict(m_tail);
      if (m_st == 1) begin
        m_mrun = (d == p && d != 0) ? m_mrun + 1 : 1;
        m_tail = d[14:0];
        if (m_mrun == 4) begin m_st = 2; m_mrun = 0; m_xrun = 0; end
      end else begin
        n = ones(d ^ p);
        m_samps++;
        m_errors += n;
        m_xrun = (n != 0) ? m_xrun + 1 : 0;
        if (m_xrun == 8) begin
          m_st = 1; m_xrun = 0; m_mrun = 0; m_tail = d[14:0];
        end else begin
          m_tail = p[14:0];
        end
      end
    end
  endfunction

  task automatic cycle(input logic r, input logic e,
                       input logic v, input logic [63:0] d);
    rst_n = r; checker_en = e; i_tvalid = v; i_tdata = d;
    model_step(r, e, v, d);
    @(posedge clk);
    #1;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b0, 64'd0);
    cycle(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++; if (locked !== 1'b0) begin errs++; $display("FAIL reset_locked got %0b exp 0", locked); end
    checks++; if (samps !== 48'd0) begin errs++; $display("FAIL reset_samps got %0d exp 0", samps); end
    checks++; if (errors !== 48'd0) begin errs++; $display("FAIL reset_errors got %0d exp 0", errors); end
    checks++; if (samps_s !== 10'd0) begin errs++; $display("FAIL reset_samps_s got %0d exp 0", samps_s); end
  endtask

  task automatic test_lock();
    int lock_at = 0;
    logic [63:0] w;
    gen_seed();
    cycle(1'b1, 1'b1, 1'b0, 64'd0);
    for (int n = 1; n <= 512; n++) begin
      w = gen_word();
      cycle(1'b1, 1'b1, 1'b1, w);
      if (locked === 1'b1 && lock_at == 0) lock_at = n;
      checks++; if (locked !== (m_st == 2)) begin errs++; $display("FAIL lock_locked n=%0d got %0b exp %0b", n, locked, m_st == 2); end
      checks++; if (samps !== 48'(m_samps)) begin errs++; $display("FAIL lock_samps n=%0d got %0d exp %0d", n, samps, m_samps); end
      checks++; if (samps_s !== 10'(sat(m_samps))) begin errs++; $display("FAIL lock_samps_s n=%0d got %0d exp %0d", n, samps_s, sat(m_samps)); end
    end
    checks++; if (lock_at != 4) begin errs++; $display("FAIL lock_latency got %0d exp 4", lock_at); end
    checks++; if (samps !== 48'd508) begin errs++; $display("FAIL lock_samps_total got %0d exp 508", samps); end
    checks++; if (errors !== 48'd0) begin errs++; $display("FAIL lock_errors got %0d exp 0", errors); end
  endtask

  task automatic test_errors();
    logic [47:0] e0 = errors;
    logic [63:0] w;
    w = gen_word();
    cycle(1'b1, 1'b1, 1'b1, w ^ (64'd1 << 5));
    checks++; if (errors !== e0 + 48'd1) begin errs++; $display("FAIL err_single got %0d exp %0d", errors, e0 + 48'd1); end
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, gen_word());
    w = gen_word();
    cycle(1'b1, 1'b1, 1'b1, w ^ 64'h8000_0000_8000_0001);
    checks++; if (errors !== e0 + 48'd4) begin errs++; $display("FAIL err_triple got %0d exp %0d", errors, e0 + 48'd4); end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b1, gen_word());
      checks++; if (locked !== 1'b1) begin errs++; $display("FAIL err_locked i=%0d got %0b exp 1", i, locked); end
      checks++; if (errors !== e0 + 48'd4) begin errs++; $display("FAIL err_hold i=%0d got %0d exp %0d", i, errors, e0 + 48'd4); end
      checks++; if (samps !== 48'(m_samps)) begin errs++; $display("FAIL err_samps i=%0d got %0d exp %0d", i, samps, m_samps); end
    end
  endtask

  task automatic test_throttle();
    logic [47:0] s0 = samps;
    logic [47:0] e0 = errors;
    int sent = 0;
    int cyc = 0;
    while (sent < 1000) begin
      if ($urandom_range(0, 1) == 1) begin
        cycle(1'b1, 1'b1, 1'b1, gen_word());
        sent++;
      end else begin
        cycle(1'b1, 1'b1, 1'b0, {$urandom, $urandom});
      end
      cyc++;
      checks++; if (samps !== 48'(m_samps)) begin errs++; $display("FAIL thr_samps c=%0d got %0d exp %0d", cyc, samps, m_samps); end
      checks++; if (samps_s !== 10'(sat(m_samps))) begin errs++; $display("FAIL thr_samps_s c=%0d got %0d exp %0d", cyc, samps_s, sat(m_samps)); end
    end
    checks++; if (samps !== s0 + 48'd1000) begin errs++; $display("FAIL thr_total got %0d exp %0d", samps, s0 + 48'd1000); end
    checks++; if (errors !== e0) begin errs++; $display("FAIL thr_errors got %0d exp %0d", errors, e0); end
    checks++; if (samps_s !== 10'h3FF) begin errs++; $display("FAIL thr_saturate got %0d exp 1023", samps_s); end
  endtask

  task automatic test_unlock();
    logic [47:0] s0 = samps;
    logic [63:0] r;
    int relock = 0;
    for (int i = 1; i <= 8; i++) begin
      void'(gen_word());
      r = {$urandom, $urandom};
      cycle(1'b1, 1'b1, 1'b1, r);
      checks++; if (locked !== (i < 8)) begin errs++; $display("FAIL unl_locked i=%0d got %0b exp %0b", i, locked, i < 8); end
      checks++; if (errors !== 48'(m_errors)) begin errs++; $display("FAIL unl_errors i=%0d got %0d exp %0d", i, errors, m_errors); end
    end
    checks++; if (samps !== s0 + 48'd8) begin errs++; $display("FAIL unl_samps got %0d exp %0d", samps, s0 + 48'd8); end
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b1, 1'b1, gen_word());
      if (locked === 1'b1 && relock == 0) relock = i;
      checks++; if (errors !== 48'(m_errors)) begin errs++; $display("FAIL rel_errors i=%0d got %0d exp %0d", i, errors, m_errors); end
    end
    checks++; if (relock != 4) begin errs++; $display("FAIL rel_latency got %0d exp 4", relock); end
    checks++; if (samps !== s0 + 48'd12) begin errs++; $display("FAIL rel_samps got %0d exp %0d", samps, s0 + 48'd12); end
  endtask

  task automatic test_sat_errors();
    for (int rep = 0; rep < 6; rep++) begin
      for (int i = 0; i < 9; i++) begin
        if (i < 7) begin
          void'(gen_word());
          cycle(1'b1, 1'b1, 1'b1, {$urandom, $urandom});
        end else begin
          cycle(1'b1, 1'b1, 1'b1, gen_word());
        end
        checks++; if (locked !== 1'b1) begin errs++; $display("FAIL sat_locked r=%0d i=%0d got %0b exp 1", rep, i, locked); end
        checks++; if (errors_s !== 10'(sat(m_errors))) begin errs++; $display("FAIL sat_errors_s r=%0d i=%0d got %0d exp %0d", rep, i, errors_s, sat(m_errors)); end
        checks++; if (errors !== 48'(m_errors)) begin errs++; $display("FAIL sat_errors r=%0d i=%0d got %0d exp %0d", rep, i, errors, m_errors); end
      end
    end
  endtask

  task automatic test_zero();
    cycle(1'b0, 1'b0, 1'b0, 64'd0);
    cycle(1'b1, 1'b1, 1'b0, 64'd0);
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 64'd0);
      checks++; if (locked !== 1'b0) begin errs++; $display("FAIL zero_locked i=%0d got %0b exp 0", i, locked); end
    end
    checks++; if (samps !== 48'd0) begin errs++; $display("FAIL zero_samps got %0d exp 0", samps); end
    checks++; if (errors !== 48'd0) begin errs++; $display("FAIL zero_errors got %0d exp 0", errors); end
  endtask

  task automatic test_enable();
    logic [47:0] s0, e0;
    logic [63:0] w;
    gen_seed();
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, 1'b1, gen_word());
    w = gen_word();
    cycle(1'b1, 1'b1, 1'b1, w ^ 64'h0000_0100_0000_0000);
    s0 = samps; e0 = errors;
    checks++; if (errors !== 48'd1) begin errs++; $display("FAIL en_preerr got %0d exp 1", errors); end
    cycle(1'b1, 1'b0, 1'b1, gen_word() ^ 64'hFF);
    checks++; if (locked !== 1'b0) begin errs++; $display("FAIL en_drop_locked got %0b exp 0", locked); end
    checks++; if (samps !== s0) begin errs++; $display("FAIL en_drop_samps got %0d exp %0d", samps, s0); end
    checks++; if (errors !== e0) begin errs++; $display("FAIL en_drop_errors got %0d exp %0d", errors, e0); end
    cycle(1'b1, 1'b0, 1'b1, gen_word());
    checks++; if (samps !== s0) begin errs++; $display("FAIL en_hold_samps got %0d exp %0d", samps, s0); end
    cycle(1'b1, 1'b1, 1'b0, 64'd0);
    checks++; if (samps !== 48'd0) begin errs++; $display("FAIL en_clear_samps got %0d exp 0", samps); end
    checks++; if (errors !== 48'd0) begin errs++; $display("FAIL en_clear_errors got %0d exp 0", errors); end
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b1, gen_word());
    w = gen_word();
    cycle(1'b1, 1'b1, 1'b1, w ^ 64'h3);
    checks++; if (locked !== 1'b1) begin errs++; $display("FAIL en_relock got %0b exp 1", locked); end
    checks++; if (errors !== 48'(m_errors)) begin errs++; $display("FAIL en_err2 got %0d exp %0d", errors, m_errors); end
    cycle(1'b0, 1'b1, 1'b1, gen_word());
    checks++; if (locked !== 1'b0) begin errs++; $display("FAIL rst_locked got %0b exp 0", locked); end
    checks++; if (samps !== 48'd0) begin errs++; $display("FAIL rst_samps got %0d exp 0", samps); end
    checks++; if (errors !== 48'd0) begin errs++; $display("FAIL rst_errors got %0d exp 0", errors); end
  endtask

  initial begin
    rst_n = 1'b0; checker_en = 1'b0; i_tvalid = 1'b0; i_tdata = '0;
    m_st = 0; m_mrun = 0; m_xrun = 0; m_tail = '0; m_samps = 0; m_errors = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_lock();
    test_errors();
    test_throttle();
    test_unlock();
    test_sat_errors();
    test_zero();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
